// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundle of the fetch-unit signals between the core side
// (redirect/flush/hold, delivered instruction) and the instruction memory
// side (request, response, address decoder).
//
// Handshake rules:
//   - A fetch request transfers on a rising edge where mem_rd & mem_ready.
//   - mem_rd and mem_addr do not depend on mem_ready.
//   - Responses come back one per mem_rvalid cycle, in request order, no
//     earlier than the cycle after acceptance.
//   - An instruction is consumed on an edge where valid & !hold, unless the
//     same cycle carries flush or pc_we.
//
// Modports:
//   slave  - the fetch unit (drives mem_rd/mem_addr and the delivery side)
//   master - the environment (core + memory + decoder)
// dbg_state exposes the fetch FSM state (0 RUN, 1 DRAIN, 2 HALT).
interface ifetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               pc_we;
    logic [ADDR_W-1:0]  pc_next;
    logic               flush;
    logic               hold;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic               hit;
    logic [2:0]         did;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_out;
    logic               valid;
    logic               fault;
    logic [1:0]         dbg_state;

    modport slave (
        input  pc_we, pc_next, flush, hold, mem_ready, mem_rvalid, mem_rdata,
               hit, did,
        output mem_rd, mem_addr, instr, pc_out, valid, fault, dbg_state
    );

    modport master (
        output pc_we, pc_next, flush, hold, mem_ready, mem_rvalid, mem_rdata,
               hit, did,
        input  mem_rd, mem_addr, instr, pc_out, valid, fault, dbg_state
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch unit with an in-order prefetch queue.
// Issues sequential fetches ahead of the consumer, buffers returned words in
// a DEPTH-entry FIFO and presents the head with valid/fault. Flush/redirect
// empty the queue and turn every in-flight request into one to be dropped.
// A fetch address the decoder does not map to ROM ends fetching with a single
// fault entry after the in-flight responses have been delivered.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ifetch_queue_if.slave (redirect/flush/hold, memory request and
//          response, decoder hit/did, delivered instr/pc_out/valid/fault,
//          dbg_state)
module ifetch_queue #(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]       ROM_DID  = 3'd0
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam int PTR_W = $clog2(DEPTH);
    // Two spare bits so count+out_cnt and out_cnt+drop_cnt never overflow.
    localparam int CNT_W = $clog2(DEPTH) + 2;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INSTR_W / 8);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUT);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fpc_q, fpc_d;
    logic [ADDR_W-1:0]  deliver_pc_q, deliver_pc_d;
    logic [ADDR_W-1:0]  push_pc_q, push_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [INSTR_W-1:0] q_instr_q [DEPTH];
    logic [INSTR_W-1:0] q_instr_d [DEPTH];
    logic [ADDR_W-1:0]  q_pc_q    [DEPTH];
    logic [ADDR_W-1:0]  q_pc_d    [DEPTH];
    logic               q_fault_q [DEPTH];
    logic               q_fault_d [DEPTH];

    logic ok;
    logic redirect;
    logic mem_rd;
    logic accept;
    logic rsp_drop;
    logic rsp_live;
    logic fault_push;
    logic data_push;
    logic valid;
    logic pop;

    // Handshake and bookkeeping strobes.
    always_comb begin
        ok       = bus.hit && (bus.did == ROM_DID);
        redirect = bus.pc_we || bus.flush;
        // Credit check: a queue slot is reserved for every live request, so
        // a returning response always has room.
        mem_rd   = !rst && (state_q == ST_RUN) && ok && !redirect &&
                   ((out_cnt_q + drop_cnt_q) < MAX_OUT_C) &&
                   ((count_q + out_cnt_q) < DEPTH_C);
        accept   = mem_rd && bus.mem_ready;
        // Stale responses are always older than live ones, so they are
        // consumed first.
        rsp_drop = bus.mem_rvalid && (drop_cnt_q != '0);
        rsp_live = bus.mem_rvalid && (drop_cnt_q == '0) && (out_cnt_q != '0);
        data_push  = rsp_live && !redirect;
        fault_push = (state_q == ST_DRAIN) && (out_cnt_q == '0) &&
                     (count_q < DEPTH_C) && !redirect;
        valid    = (count_q != '0);
        pop      = valid && !bus.hold && !redirect;
    end

    // Next-state logic for FSM, PCs, counters and queue storage.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        deliver_pc_d = deliver_pc_q;
        push_pc_d    = push_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        q_instr_d    = q_instr_q;
        q_pc_d       = q_pc_q;
        q_fault_d    = q_fault_q;

        if (accept) begin
            fpc_d = fpc_q + STEP;
        end
        out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(rsp_live);
        drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);

        if (data_push || fault_push) begin
            q_instr_d[wr_ptr_q] = fault_push ? '0 : bus.mem_rdata;
            q_pc_d[wr_ptr_q]    = fault_push ? fpc_q : push_pc_q;
            q_fault_d[wr_ptr_q] = fault_push;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            push_pc_d           = push_pc_q + STEP;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            deliver_pc_d = deliver_pc_q + STEP;
        end
        count_d = count_q + CNT_W'(data_push || fault_push) - CNT_W'(pop);

        case (state_q)
            ST_RUN:   if (!ok) state_d = ST_DRAIN;
            ST_DRAIN: if (fault_push) state_d = ST_HALT;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase

        // Redirect wins over everything above. A response arriving in this
        // cycle has already been subtracted from out_cnt_d/drop_cnt_d, so
        // only requests still in flight become drops.
        if (redirect) begin
            state_d    = ST_RUN;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_cnt_d = drop_cnt_d + out_cnt_d;
            out_cnt_d  = '0;
            if (bus.pc_we) begin
                fpc_d        = bus.pc_next;
                deliver_pc_d = bus.pc_next;
                push_pc_d    = bus.pc_next;
            end else begin
                fpc_d        = deliver_pc_q;
                deliver_pc_d = deliver_pc_q;
                push_pc_d    = deliver_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            fpc_q        <= RESET_PC;
            deliver_pc_q <= RESET_PC;
            push_pc_q    <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            out_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            deliver_pc_q <= deliver_pc_d;
            push_pc_q    <= push_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            out_cnt_q    <= out_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
        q_fault_q <= q_fault_d;
    end

    // With the queue empty, pc_out shows the PC that will be delivered next.
    always_comb begin
        bus.mem_rd    = mem_rd;
        bus.mem_addr  = fpc_q;
        bus.valid     = valid;
        bus.instr     = valid ? q_instr_q[rd_ptr_q] : '0;
        bus.pc_out    = valid ? q_pc_q[rd_ptr_q] : deliver_pc_q;
        bus.fault     = valid && q_fault_q[rd_ptr_q];
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue. A ROM model with a
// configurable latency answers fetch requests in order; a second instance
// with RESET_PC near the top of the address space covers PC wrap.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
    ifetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus_w ();

    ifetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .MAX_OUT(2),
                   .RESET_PC(32'h0), .ROM_DID(3'd0))
        dut (.clk(clk), .rst(rst), .bus(bus));

    ifetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .MAX_OUT(2),
                   .RESET_PC(32'hFFFF_FFFC), .ROM_DID(3'd0))
        dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    // Decoder: ROM occupies addresses below hit_limit.
    logic [31:0] hit_limit = 32'hFFFF_FFFF;
    assign bus.hit = (bus.mem_addr < hit_limit);

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ROM model: works at the falling edge so its outputs are stable around
    // the rising edge. Requests seen at a falling edge are accepted at the
    // following rising edge and answered lat cycles later.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rom_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.mem_rvalid = 1'b0;
                end
                if (bus.mem_rd && bus.mem_ready) begin
                    pend_addr.push_back(bus.mem_addr);
                    pend_due.push_back(cyc + lat);
                end
            end
        end
    end

    // Reset for three edges, then leave the caller in cycle 1 with rst low.
    task automatic do_reset();
        bus.pc_we = 1'b0;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pc_we     = 1'b0;
        bus.pc_next   = '0;
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.did       = 3'd0;
        bus_w.pc_we      = 1'b0;
        bus_w.pc_next    = '0;
        bus_w.flush      = 1'b0;
        bus_w.hold       = 1'b0;
        bus_w.mem_ready  = 1'b1;
        bus_w.mem_rvalid = 1'b0;
        bus_w.mem_rdata  = '0;
        bus_w.hit        = 1'b1;
        bus_w.did        = 3'd0;

        // Reset state.
        repeat (3) tick();
        check_eq("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_fault", 32'(bus.fault), 32'd0);
        check_eq("rst_instr", bus.instr, 32'h0);
        check_eq("rst_pc_out", bus.pc_out, 32'h0);
        check_eq("rst_state", 32'(bus.dbg_state), 32'd0);
        check_eq("rst_w_pc_out", bus_w.pc_out, 32'hFFFF_FFFC);

        // Streaming with a 1-cycle ROM: one instruction per cycle from cycle 3.
        lat = 1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
        for (int t = 1; t <= 8; t++) begin
            if (t > 1) tick();
            #1;
            check_eq("stream_mem_rd", 32'(bus.mem_rd), 32'd1);
            check_eq("stream_mem_addr", bus.mem_addr, 32'(4 * (t - 1)));
            if (t == 1) begin
                check_eq("wrap_addr0", bus_w.mem_addr, 32'hFFFF_FFFC);
                check_eq("wrap_rd0", 32'(bus_w.mem_rd), 32'd1);
            end
            if (t == 2) check_eq("wrap_addr1", bus_w.mem_addr, 32'h0);
            if (t < 3) begin
                check_eq("stream_early_valid", 32'(bus.valid), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_eq("stream_valid", 32'(bus.valid), 32'd1);
                check_eq("stream_pc_out", bus.pc_out, e);
                check_eq("stream_instr", bus.instr, rom_word(e));
            end
        end

        // Hold for 10 cycles fills exactly DEPTH entries, then drains back-to-back.
        do_reset();
        bus.hold = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            if (t > 1) tick();
            if (t == 11) bus.hold = 1'b0;
            #1;
            if (t >= 6 && t <= 10)
                check_eq("hold_mem_rd", 32'(bus.mem_rd), 32'd0);
            if (t == 10) begin
                check_eq("hold_mem_addr", bus.mem_addr, 32'h10);
                check_eq("hold_valid", 32'(bus.valid), 32'd1);
                check_eq("hold_pc_out", bus.pc_out, 32'h0);
            end
            if (t >= 11) begin
                check_eq("release_valid", 32'(bus.valid), 32'd1);
                check_eq("release_pc_out", bus.pc_out, 32'(4 * (t - 11)));
            end
        end

        // Redirect with two requests in flight at 3-cycle latency.
        lat = 3;
        do_reset();
        tick();
        tick();
        #1;
        check_eq("redir_credit_block", 32'(bus.mem_rd), 32'd0);
        bus.pc_we   = 1'b1;
        bus.pc_next = 32'h100;
        tick();
        bus.pc_we = 1'b0;
        #1;
        check_eq("redir_valid_low", 32'(bus.valid), 32'd0);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 30 && !seen; t++) begin
                if (bus.valid) begin
                    seen = 1'b1;
                    check_eq("redir_pc_out", bus.pc_out, 32'h100);
                    check_eq("redir_instr", bus.instr, rom_word(32'h100));
                end else begin
                    tick();
                    #1;
                end
            end
            if (!seen) check_eq("redir_timeout", 32'd0, 32'd1);
        end
        tick();
        #1;
        check_eq("redir_next_pc", bus.pc_out, 32'h104);

        // Flush with deliver_pc=0x8 and queue holding 0x8, 0xC.
        lat = 1;
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            if (t > 1) tick();
            if (t == 5) bus.hold = 1'b1;
            if (t == 6) bus.flush = 1'b1;
            if (t == 7) begin
                bus.flush = 1'b0;
                bus.hold  = 1'b0;
            end
            #1;
            if (t == 6) check_eq("flush_head", bus.pc_out, 32'h8);
            if (t == 7) begin
                check_eq("flush_valid", 32'(bus.valid), 32'd0);
                check_eq("flush_mem_rd", 32'(bus.mem_rd), 32'd1);
                check_eq("flush_refetch", bus.mem_addr, 32'h8);
            end
            if (t == 9) begin
                check_eq("flush_first_valid", 32'(bus.valid), 32'd1);
                check_eq("flush_first_pc", bus.pc_out, 32'h8);
            end
            if (t == 10) check_eq("flush_second_pc", bus.pc_out, 32'hC);
        end

        // Fetch runs off the end of ROM at 0x40.
        hit_limit = 32'h40;
        do_reset();
        for (int t = 1; t <= 24; t++) begin
            if (t > 1) tick();
            if (t == 23) begin
                bus.pc_we   = 1'b1;
                bus.pc_next = 32'h0;
            end
            if (t == 24) bus.pc_we = 1'b0;
            #1;
            if (t >= 17 && t <= 23)
                check_eq("fault_mem_rd", 32'(bus.mem_rd), 32'd0);
            if (t == 17) check_eq("fault_pc_38", bus.pc_out, 32'h38);
            if (t == 18) begin
                check_eq("fault_pc_3c", bus.pc_out, 32'h3C);
                check_eq("fault_pre", 32'(bus.fault), 32'd0);
            end
            if (t == 19) begin
                check_eq("fault_valid", 32'(bus.valid), 32'd1);
                check_eq("fault_flag", 32'(bus.fault), 32'd1);
                check_eq("fault_pc", bus.pc_out, 32'h40);
                check_eq("fault_instr", bus.instr, 32'h0);
                check_eq("fault_state", 32'(bus.dbg_state), 32'd2);
            end
            if (t == 20) check_eq("fault_once", 32'(bus.valid), 32'd0);
            if (t == 24) begin
                check_eq("fault_exit_rd", 32'(bus.mem_rd), 32'd1);
                check_eq("fault_exit_addr", bus.mem_addr, 32'h0);
                check_eq("fault_exit_state", 32'(bus.dbg_state), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch unit with a prefetch queue, sitting between the PC/redirect logic and instruction ROM. It issues sequential fetch requests ahead of the consumer, buffers returned instructions in a DEPTH-entry in-order queue, and presents them with a valid flag under hold back-pressure. Flush and redirect discard queued and in-flight instructions; non-ROM addresses produce a single fault entry.

## Interface
- ADDR_W, 32, address width (from params_pkg)
- INSTR_W, 32, instruction width (from params_pkg); power of two, ≥ 8
- DEPTH, 4, queue entries (power of two, ≥ 2)
- MAX_OUT, 2, maximum outstanding memory requests (1..DEPTH)
- RESET_PC, 0, fetch/deliver PC after reset
- ROM_DID, 3'd0, decoder device id that marks instruction ROM

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_we  in  1  redirect strobe; implies flush
- pc_next  in  ADDR_W  redirect target
- flush  in  1  discard queue and in-flight; refetch from deliver_pc
- hold  in  1  consumer stall
- mem_rd  out  1  fetch request
- mem_addr  out  ADDR_W  fetch address (= fpc)
- mem_ready  in  1  memory accepts request when mem_rd & mem_ready
- mem_rvalid  in  1  response valid; responses return in request order
- mem_rdata  in  INSTR_W  response data
- hit  in  1  decoder: mem_addr maps to a device
- did  in  3  decoder device id for mem_addr
- instr  out  INSTR_W  head-of-queue instruction
- pc_out  out  ADDR_W  PC of instr
- valid  out  1  head entry present
- fault  out  1  head entry is a fetch fault (instr = 0)

## Operation
- Registers: fpc (next fetch PC), deliver_pc (PC of next instruction to deliver), queue[DEPTH] of {instr, pc, fault}, out_cnt (live outstanding), drop_cnt (outstanding to discard), state.
- Step = INSTR_W/8; all PC arithmetic modulo 2^ADDR_W (wraps silently).
- ok = hit & (did == ROM_DID).
- States: RUN, DRAIN, HALT.
  - RUN: mem_rd = ok & (out_cnt+drop_cnt < MAX_OUT) & (count+out_cnt < DEPTH) & !flush & !pc_we. Accept (mem_rd & mem_ready): fpc += Step, out_cnt++. If !ok → DRAIN (no request).
  - DRAIN: mem_rd = 0; when out_cnt == 0 and queue not full, push {0, fpc, fault=1} → HALT.
  - HALT: mem_rd = 0; leave only on flush/pc_we.
- Response: if drop_cnt > 0, discard and drop_cnt--; else push {mem_rdata, pc, 0}, out_cnt--. Entry pc is tracked by a push-side PC register advanced per push.
- Consume = valid & !hold & !flush & !pc_we: pop head, deliver_pc += Step.
- Flush/pc_we (same-cycle response counted first): queue emptied, drop_cnt += out_cnt, out_cnt = 0, state → RUN; fpc and deliver_pc and push-PC ← pc_next if pc_we, else fpc and push-PC ← deliver_pc. pc_we has priority over flush.
- Queue never overflows: credit check reserves a slot per outstanding request.

## Timing
- Reset values: mem_rd 0 during rst, mem_addr RESET_PC, valid 0, fault 0, instr 0, pc_out RESET_PC, out_cnt/drop_cnt 0, state RUN.
- First mem_rd in first cycle after rst deasserts (if ok and mem_ready irrelevant to assertion).
- mem_rd/mem_addr combinational from registered state plus hit/did/flush/pc_we; mem_rdata pushed at edge of mem_rvalid cycle; valid rises next cycle (response-to-valid latency 1).
- mem_rvalid earliest one cycle after acceptance.
- Steady state with 1-cycle memory, MAX_OUT ≥ 2, hold=0: one instruction per cycle.
- Push and pop in same cycle allowed at full and empty.
- Redirect cycle: valid drops next cycle; first new request issued the cycle after pc_we.
- rst mid-operation: all state cleared next edge; later stray mem_rvalid with out_cnt=drop_cnt=0 is ignored.

## Test plan
- Reset, 1-cycle ROM, hold=0 → mem_addr 0,4,8,…; valid from cycle 3 onward, pc_out increments by 4 every cycle.
- hold=1 for 10 cycles → exactly 4 entries queued, mem_rd deasserts; release → 4 back-to-back deliveries with no gaps, pc_out 0,4,8,12.
- pc_we with pc_next=0x100 while 2 requests in flight (3-cycle latency) → both stale responses dropped, next valid entry pc_out=0x100.
- flush alone with deliver_pc=0x8 and queue holding 0x8,0xC → queue cleared, refetch starts at 0x8.
- fpc reaches 0x40 where hit=0 → in-flight 0x38,0x3C delivered, then fault=1 pc_out=0x40, mem_rd stays 0 until pc_we.
- RESET_PC=0xFFFFFFFC → second fetch address wraps to 0x0.
